// File: rtl/csr_trap_if.sv
// Bundle of the decoder-side strobes and instruction fields that drive the CSR/trap unit,
// together with the unit's writeback and redirect results.
interface csr_trap_if #(parameter int XLEN = 32);
   logic            instr_valid;
   logic            csr_wen;
   logic            ecall;
   logic            mret;
   logic [2:0]      func3;
   logic [11:0]     csr_addr;
   logic [4:0]      rs1_idx;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] csr_rdata;
   logic            trap_taken;
   logic [XLEN-1:0] trap_pc;
   logic            illegal_csr;

   modport master (
      output instr_valid, csr_wen, ecall, mret, func3, csr_addr, rs1_idx, rs1_data, pc,
      input  csr_rdata, trap_taken, trap_pc, illegal_csr
   );

   modport slave (
      input  instr_valid, csr_wen, ecall, mret, func3, csr_addr, rs1_idx, rs1_data, pc,
      output csr_rdata, trap_taken, trap_pc, illegal_csr
   );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and ecall/mret trap responder for the single-cycle core.
// Reads return the pre-edge value; all updates land on the rising clock edge.
module csr_trap_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MSTATUS_RST = 32'h1800,
   parameter logic [XLEN-1:0] MTVEC_RST   = 32'h0,
   parameter logic [XLEN-1:0] MVENDORID   = 32'h79737978,
   parameter logic [XLEN-1:0] MARCHID     = 32'h0
) (
   input logic       clk,
   input logic       rst,
   csr_trap_if.slave bus
);
   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;

   logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
   logic [63:0]     mcycle;
   logic [63:0]     mcycle_inc;
   logic [XLEN-1:0] old_val, src, new_val;
   logic            mapped, read_only, set_clr_nop, op_valid, csr_we, do_ecall, do_mret;

   always_comb begin
      old_val   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      unique case (bus.csr_addr)
         A_MSTATUS:   old_val = mstatus;
         A_MTVEC:     old_val = mtvec;
         A_MEPC:      old_val = mepc;
         A_MCAUSE:    old_val = mcause;
         A_MCYCLE:    old_val = mcycle[31:0];
         A_MCYCLEH:   old_val = mcycle[63:32];
         A_MVENDORID: begin old_val = MVENDORID; read_only = 1'b1; end
         A_MARCHID:   begin old_val = MARCHID;   read_only = 1'b1; end
         default:     mapped  = 1'b0;
      endcase
   end

   // Immediate forms reuse the rs1 field as a 5-bit zero-extended operand.
   assign src = bus.func3[2] ? {{(XLEN-5){1'b0}}, bus.rs1_idx} : bus.rs1_data;

   always_comb begin
      new_val  = old_val;
      op_valid = 1'b1;
      unique case (bus.func3[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_val | src;
         2'b11:   new_val = old_val & ~src;
         default: op_valid = 1'b0;
      endcase
   end

   assign set_clr_nop = bus.func3[1] && (bus.rs1_idx == 5'd0);
   assign do_ecall    = bus.instr_valid && bus.ecall;
   assign do_mret     = bus.instr_valid && bus.mret && !bus.ecall;
   // The decoder raises csr_wen on ecall/mret too, so those must mask the write path.
   assign csr_we      = bus.instr_valid && bus.csr_wen && !bus.ecall && !bus.mret &&
                        mapped && !read_only && !set_clr_nop && op_valid;
   assign mcycle_inc  = mcycle + 64'd1;

   assign bus.csr_rdata   = old_val;
   assign bus.trap_taken  = do_ecall || do_mret;
   assign bus.trap_pc     = bus.ecall ? {mtvec[XLEN-1:2], 2'b00} : (bus.mret ? mepc : '0);
   assign bus.illegal_csr = bus.instr_valid && bus.csr_wen && !bus.ecall && !bus.mret && !mapped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus <= MSTATUS_RST;
         mtvec   <= MTVEC_RST;
         mepc    <= '0;
         mcause  <= '0;
         mcycle  <= '0;
      end else begin
         if (csr_we && bus.csr_addr == A_MCYCLE)
            mcycle <= {mcycle_inc[63:32], new_val};
         else if (csr_we && bus.csr_addr == A_MCYCLEH)
            mcycle <= {new_val, mcycle_inc[31:0]};
         else
            mcycle <= mcycle_inc;

         if (do_ecall) begin
            mepc          <= {bus.pc[XLEN-1:2], 2'b00};
            mcause        <= XLEN'(11);
            mstatus[7]    <= mstatus[3];
            mstatus[3]    <= 1'b0;
            mstatus[12:11] <= 2'b11;
         end else if (do_mret) begin
            mstatus[3]    <= mstatus[7];
            mstatus[7]    <= 1'b1;
            mstatus[12:11] <= 2'b11;
         end else if (csr_we) begin
            unique case (bus.csr_addr)
               A_MSTATUS: mstatus <= new_val;
               A_MTVEC:   mtvec   <= new_val;
               A_MEPC:    mepc    <= {new_val[XLEN-1:2], 2'b00};
               A_MCAUSE:  mcause  <= new_val;
               default:   ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: driver pushes reference-model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_csr_trap_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_trap_if #(.XLEN(32)) bus ();
   csr_trap_unit dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [11:0] addr;
      logic [31:0] rdata;
      logic        taken;
      logic [31:0] tpc;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state, advanced once per clock edge by the driver.
   logic [31:0] m_status, m_tvec, m_epc, m_cause;
   logic [63:0] m_cycle;

   task automatic model_reset();
      m_status = 32'h1800;
      m_tvec   = 32'h0;
      m_epc    = 32'h0;
      m_cause  = 32'h0;
      m_cycle  = 64'h0;
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a, output logic mapped, output logic ro);
      mapped = 1'b1;
      ro     = 1'b0;
      case (a)
         12'h300: return m_status;
         12'h305: return m_tvec;
         12'h341: return m_epc;
         12'h342: return m_cause;
         12'hB00: return m_cycle[31:0];
         12'hB80: return m_cycle[63:32];
         12'hF11: begin ro = 1'b1; return 32'h79737978; end
         12'hF12: begin ro = 1'b1; return 32'h0; end
         default: begin mapped = 1'b0; return 32'h0; end
      endcase
   endfunction

   task automatic issue(input logic v, input logic wen, input logic ec, input logic mr,
                        input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] d, input logic [31:0] pcv);
      exp_t        e;
      logic        mapped, ro, is_write;
      logic [31:0] old, src, nv;
      logic [63:0] nxt;
      logic        mie, mpie;
      bus.instr_valid = v;   bus.csr_wen = wen; bus.ecall = ec; bus.mret = mr;
      bus.func3 = f3;        bus.csr_addr = a;  bus.rs1_idx = r1;
      bus.rs1_data = d;      bus.pc = pcv;

      old     = model_read(a, mapped, ro);
      e.addr  = a;
      e.rdata = old;
      e.taken = v && (ec || mr);
      e.tpc   = ec ? (m_tvec & ~32'd3) : m_epc;
      e.ill   = v && wen && !ec && !mr && !mapped;
      q.push_back(e);

      nxt  = m_cycle + 64'd1;
      mie  = m_status[3];
      mpie = m_status[7];
      src  = (f3 >= 3'd5) ? 32'(r1) : d;
      case (f3)
         3'd1, 3'd5: nv = src;
         3'd2, 3'd6: nv = old | src;
         default:    nv = old & ~src;
      endcase
      is_write = v && wen && !ec && !mr && mapped && !ro &&
                 (f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) &&
                 !((f3 inside {3'd2, 3'd3, 3'd6, 3'd7}) && r1 == 5'd0);
      if (v && ec) begin
         m_epc    = pcv & ~32'd3;
         m_cause  = 32'd11;
         m_status = (m_status & ~32'h0000_1888) | 32'h1800 | (mie ? 32'h80 : 32'h0);
      end else if (v && mr) begin
         m_status = (m_status & ~32'h0000_1888) | 32'h1880 | (mpie ? 32'h8 : 32'h0);
      end else if (is_write) begin
         case (a)
            12'h300: m_status = nv;
            12'h305: m_tvec   = nv;
            12'h341: m_epc    = nv & ~32'd3;
            12'h342: m_cause  = nv;
            12'hB00: nxt = (nxt & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
            12'hB80: nxt = (nxt & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
            default: ;
         endcase
      end
      m_cycle = nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1, input logic [31:0] d);
      issue(1'b1, 1'b1, 1'b0, 1'b0, f3, a, r1, d, 32'h8000_0000);
   endtask

   task automatic rd(input logic [11:0] a);
      csr(3'd2, a, 5'd0, 32'h0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.csr_rdata !== e.rdata) begin
               n_bad++;
               $display("FAIL rdata addr=%h: got %h expected %h", e.addr, bus.csr_rdata, e.rdata);
            end
            n_cmp++;
            if (bus.trap_taken !== e.taken) begin
               n_bad++;
               $display("FAIL trap_taken addr=%h: got %b expected %b", e.addr, bus.trap_taken, e.taken);
            end
            n_cmp++;
            if (bus.illegal_csr !== e.ill) begin
               n_bad++;
               $display("FAIL illegal_csr addr=%h: got %b expected %b", e.addr, bus.illegal_csr, e.ill);
            end
            if (e.taken) begin
               n_cmp++;
               if (bus.trap_pc !== e.tpc) begin
                  n_bad++;
                  $display("FAIL trap_pc: got %h expected %h", bus.trap_pc, e.tpc);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [11:0] addrs [11];
      logic [2:0]  ops [6];
      int          r;
      addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                12'hF11, 12'hF12, 12'h7C0, 12'h000, 12'h301};
      ops   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
      bus.instr_valid = 0; bus.csr_wen = 0; bus.ecall = 0; bus.mret = 0;
      bus.func3 = 0; bus.csr_addr = 0; bus.rs1_idx = 0; bus.rs1_data = 0; bus.pc = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      issue(0, 0, 0, 0, 3'd0, 12'h000, 5'd0, 32'h0, 32'h0);
      rd(12'h300);
      rd(12'h300);
      // mtvec write, then ecall vectors to the aligned base
      csr(3'd1, 12'h305, 5'd1, 32'h8000_0103);
      rd(12'h305);
      issue(1, 1, 1, 0, 3'd0, 12'h000, 5'd0, 32'h0, 32'h8000_0010);
      rd(12'h341);
      rd(12'h342);
      rd(12'h300);
      // MIE set, ecall, mret restores it
      csr(3'd6, 12'h300, 5'd8, 32'h0);
      issue(1, 1, 1, 0, 3'd0, 12'h000, 5'd0, 32'h0, 32'h8000_0020);
      rd(12'h300);
      issue(1, 1, 0, 1, 3'd0, 12'h302, 5'd0, 32'h0, 32'h8000_0100);
      rd(12'h300);
      // set/clear immediates and rs1=x0 no-op
      csr(3'd6, 12'h300, 5'd8, 32'h0);
      rd(12'h300);
      csr(3'd7, 12'h300, 5'd8, 32'h0);
      rd(12'h300);
      csr(3'd3, 12'h300, 5'd0, 32'hFFFF_FFFF);
      rd(12'h300);
      // mcycle wrap
      csr(3'd1, 12'hB80, 5'd1, 32'hFFFF_FFFF);
      csr(3'd1, 12'hB00, 5'd1, 32'hFFFF_FFFF);
      rd(12'hB00);
      rd(12'hB00);
      rd(12'hB00);
      rd(12'hB80);
      // illegal and read-only targets, stalled ecall, ecall+mret together
      csr(3'd1, 12'h7C0, 5'd1, 32'h1234_5678);
      rd(12'h7C0);
      csr(3'd1, 12'hF11, 5'd1, 32'hDEAD_BEEF);
      rd(12'hF11);
      rd(12'hF12);
      issue(0, 1, 1, 0, 3'd0, 12'h000, 5'd0, 32'h0, 32'h0000_0044);
      rd(12'h341);
      csr(3'd1, 12'h341, 5'd1, 32'h0000_0207);
      issue(1, 1, 1, 1, 3'd0, 12'h000, 5'd0, 32'h0, 32'h0000_0300);
      rd(12'h341);
      rd(12'h300);

      // asynchronous reset mid-run
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      rd(12'h300);
      rd(12'hB00);
      rd(12'h305);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         issue(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
               (r < 8), (r >= 8 && r < 16),
               ops[$urandom_range(0, 5)], addrs[$urandom_range(0, 10)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      end

      bus.instr_valid = 0; bus.csr_wen = 0; bus.ecall = 0; bus.mret = 0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
